meas_scheduler: RTL and testbench

Round-robin sequencer that time-shares one period-measurement core across N_CH multiplexed NE555 sensor inputs. It drives the input-mux select, holds the measurement core in reset while the mux settles, and waits for the core's result or a timeout. It then presents a tagged result, made up of channel, count and timeout flag, to a downstream consumer over a valid/ready handshake. It sits between the sensor mux / period-measurement core and the result consumer.

---
 rtl/meas_scheduler.sv | 124 ++++++++++++
 tb/tb_meas_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/meas_scheduler.sv
// meas_scheduler: round-robin sequencer that shares one period-measurement core
// across N_CH multiplexed sensor inputs. For each channel it selects the mux,
// holds the core in reset while the mux settles, waits for a result or a
// timeout, and hands a tagged result to the consumer.
//
// Result handshake: res_valid rises when a result is latched and stays high,
// with res_data/res_ch/res_timeout/res_last frozen, until a cycle where
// res_valid & res_ready are both 1; that edge is the transfer, res_valid
// drops after it and the next channel starts. res_valid never depends on
// res_ready, and a result is never dropped or overwritten.
module meas_scheduler #(
    parameter int N_CH           = 4,
    parameter int CH_W           = 2,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            meas_valid,
    input  logic [31:0]     meas_data,
    output logic            meas_rst,
    output logic [CH_W-1:0] ch_sel,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [31:0]     res_data,
    output logic [CH_W-1:0] res_ch,
    output logic            res_timeout,
    output logic            res_last,
    output logic            busy
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SETTLE_LAST  = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST      = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    // Current state is kept as a named signal so checkers can bind to it.
    state_t state;
    state_t state_nxt;

    logic [SET_W-1:0] settle_cnt;
    logic [31:0]      timer;
    logic             timed_out;
    logic             accept;

    assign timed_out = (timer == TIMEOUT_LAST);
    assign accept    = (state == OUTPUT) && res_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a result already in flight always completes its
    // handshake even if enable drops, and enable is only consulted afterwards.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = MEASURE;
            MEASURE: if (meas_valid || timed_out) state_nxt = OUTPUT;
            OUTPUT:  if (res_ready) state_nxt = enable ? SETTLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, core reset, mux select and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt  <= '0;
            timer       <= '0;
            meas_rst    <= 1'b1;
            ch_sel      <= '0;
            res_data    <= '0;
            res_ch      <= '0;
            res_timeout <= 1'b0;
        end else begin
            // Core runs only while measuring; registered from next state so
            // it falls exactly on MEASURE entry and rises on MEASURE exit.
            meas_rst <= (state_nxt != MEASURE);

            // Both counters restart at zero on every entry to their state.
            if (state == SETTLE && state_nxt == SETTLE) begin
                settle_cnt <= settle_cnt + 1'b1;
            end else begin
                settle_cnt <= '0;
            end

            if (state == MEASURE && state_nxt == MEASURE) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end

            // A real measurement wins over a coincident timeout.
            if (state == MEASURE && state_nxt == OUTPUT) begin
                res_data    <= meas_valid ? meas_data : 32'hFFFF_FFFF;
                res_timeout <= ~meas_valid;
                res_ch      <= ch_sel;
            end

            if (accept) begin
                ch_sel <= (ch_sel == CH_LAST) ? '0 : ch_sel + 1'b1;
            end
        end
    end

    assign res_valid = (state == OUTPUT);
    assign busy      = (state != IDLE);
    assign res_last  = (res_ch == CH_LAST);

endmodule

// File: tb/tb_meas_scheduler.sv
// Bench for meas_scheduler: table of per-channel transactions (when the model
// core answers, what it returns, how long the consumer stalls, and the
// expected tagged result), plus hand-written enable-drop and reset sequences.
module tb_meas_scheduler;

    localparam int N_CH    = 4;
    localparam int CH_W    = 2;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 100;

    logic            clk;
    logic            reset;
    logic            enable;
    logic            meas_valid;
    logic [31:0]     meas_data;
    logic            meas_rst;
    logic [CH_W-1:0] ch_sel;
    logic            res_valid;
    logic            res_ready;
    logic [31:0]     res_data;
    logic [CH_W-1:0] res_ch;
    logic            res_timeout;
    logic            res_last;
    logic            busy;

    int n_vec;
    int n_err;

    typedef struct {
        int          mv_cycle;  // MEASURE cycle (1-based) of the meas_valid pulse, 0 = never
        logic [31:0] data;
        int          hold;      // cycles res_ready stays low once res_valid is seen
        int          exp_lat;   // cycles from MEASURE entry to res_valid
        logic [31:0] exp_data;
        logic [1:0]  exp_ch;
        logic        exp_to;
        logic        exp_last;
    } vec_t;

    vec_t vecs[14];

    meas_scheduler #(
        .N_CH(N_CH), .CH_W(CH_W), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .meas_valid(meas_valid), .meas_data(meas_data), .meas_rst(meas_rst),
        .ch_sel(ch_sel), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_ch(res_ch), .res_timeout(res_timeout),
        .res_last(res_last), .busy(busy)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int mv, input logic [31:0] d, input int hold,
                                input int lat, input logic [31:0] ed, input logic [1:0] ch,
                                input logic to, input logic last);
        vec_t v;
        v.mv_cycle = mv; v.data = d; v.hold = hold; v.exp_lat = lat;
        v.exp_data = ed; v.exp_ch = ch; v.exp_to = to; v.exp_last = last;
        return v;
    endfunction

    // Wait out SETTLE (called on its first cycle); returns its length.
    task automatic wait_measure(output int settle);
        settle = 0;
        while (meas_rst === 1'b1 && settle < 50) begin
            settle++;
            step();
        end
    endtask

    // One channel: settle, model core answer / timeout, result, stall, accept.
    task automatic run_vec(input vec_t v, input int idx);
        int settle;
        int lat;
        int bad;
        logic [31:0] d0;
        logic [1:0]  nx;
        wait_measure(settle);
        check($sformatf("v%0d settle_len", idx), settle, SETTLE);
        check($sformatf("v%0d ch_sel_meas", idx), ch_sel, v.exp_ch);
        lat = 0;
        while (lat < 300) begin
            if (lat + 1 == v.mv_cycle) begin
                meas_valid = 1'b1;
                meas_data  = v.data;
            end
            step();
            lat++;
            meas_valid = 1'b0;
            meas_data  = 32'h0;
            if (res_valid === 1'b1) break;
        end
        check($sformatf("v%0d latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d res_data", idx), res_data, v.exp_data);
        check($sformatf("v%0d res_ch", idx), res_ch, v.exp_ch);
        check($sformatf("v%0d res_timeout", idx), res_timeout, v.exp_to);
        check($sformatf("v%0d res_last", idx), res_last, v.exp_last);
        check($sformatf("v%0d meas_rst_out", idx), meas_rst, 1'b1);
        if (v.hold > 0) begin
            bad = 0;
            d0  = res_data;
            for (int i = 0; i < v.hold; i++) begin
                step();
                if (res_valid !== 1'b1 || res_data !== d0 || res_ch !== v.exp_ch ||
                    res_timeout !== v.exp_to || res_last !== v.exp_last ||
                    ch_sel !== v.exp_ch || meas_rst !== 1'b1) bad++;
            end
            check($sformatf("v%0d hold_stable", idx), bad, 0);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        nx = v.exp_ch + 2'd1;
        check($sformatf("v%0d valid_drop", idx), res_valid, 1'b0);
        check($sformatf("v%0d ch_advance", idx), ch_sel, nx);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " meas_rst"}, meas_rst, 1'b1);
        check({tag, " ch_sel"}, ch_sel, 2'd0);
        check({tag, " res_valid"}, res_valid, 1'b0);
        check({tag, " res_data"}, res_data, 32'h0);
        check({tag, " res_ch"}, res_ch, 2'd0);
        check({tag, " res_timeout"}, res_timeout, 1'b0);
        check({tag, " res_last"}, res_last, 1'b0);
        check({tag, " busy"}, busy, 1'b0);
    endtask

    initial begin
        int settle;
        int lat;
        n_vec = 0;
        n_err = 0;
        reset      = 1'b1;
        enable     = 1'b0;
        meas_valid = 1'b0;
        meas_data  = 32'h0;
        res_ready  = 1'b0;

        //              mv   data          hold lat  exp_data      ch    to    last
        vecs[0]  = mk(10,  32'h1234,     0,  10,  32'h1234,     2'd0, 1'b0, 1'b0);
        vecs[1]  = mk(3,   32'd1001,     0,  3,   32'd1001,     2'd1, 1'b0, 1'b0);
        vecs[2]  = mk(7,   32'd1002,     0,  7,   32'd1002,     2'd2, 1'b0, 1'b0);
        vecs[3]  = mk(1,   32'd1003,     0,  1,   32'd1003,     2'd3, 1'b0, 1'b1);
        vecs[4]  = mk(20,  32'd1000,     0,  20,  32'd1000,     2'd0, 1'b0, 1'b0);
        vecs[5]  = mk(5,   32'd1001,     0,  5,   32'd1001,     2'd1, 1'b0, 1'b0);
        vecs[6]  = mk(0,   32'h0,        0,  100, 32'hFFFF_FFFF, 2'd2, 1'b1, 1'b0);
        vecs[7]  = mk(2,   32'd1003,     0,  2,   32'd1003,     2'd3, 1'b0, 1'b1);
        vecs[8]  = mk(100, 32'hBEEF,     0,  100, 32'hBEEF,     2'd0, 1'b0, 1'b0);
        vecs[9]  = mk(4,   32'h55,       50, 4,   32'h55,       2'd1, 1'b0, 1'b0);
        vecs[10] = mk(6,   32'h66,       0,  6,   32'h66,       2'd2, 1'b0, 1'b0);
        vecs[11] = mk(2,   32'hA5A5_0003, 0, 2,   32'hA5A5_0003, 2'd3, 1'b0, 1'b1);
        vecs[12] = mk(2,   32'h0,        3,  2,   32'h0,        2'd0, 1'b0, 1'b0);
        vecs[13] = mk(9,   32'h2222,     0,  9,   32'h2222,     2'd2, 1'b0, 1'b0);

        // Reset state.
        repeat (3) step();
        check_reset_values("rst");
        reset = 1'b0;
        step();
        check("idle busy", busy, 1'b0);
        check("idle meas_rst", meas_rst, 1'b1);
        enable = 1'b1;
        step();
        check("enter busy", busy, 1'b1);

        // Sweeps: first result, full sweep with wrap, timeout, coincidence, backpressure.
        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], i);
        end

        // Enable dropped while measuring ch 1: result still delivered, then IDLE.
        wait_measure(settle);
        check("drop settle_len", settle, SETTLE);
        check("drop ch_sel", ch_sel, 2'd1);
        step();
        step();
        enable = 1'b0;
        step();
        meas_valid = 1'b1;
        meas_data  = 32'h77;
        step();
        meas_valid = 1'b0;
        check("drop res_valid", res_valid, 1'b1);
        check("drop res_data", res_data, 32'h77);
        check("drop res_ch", res_ch, 2'd1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("drop busy", busy, 1'b0);
        check("drop ch_sel_next", ch_sel, 2'd2);
        check("drop res_valid_low", res_valid, 1'b0);
        // A stray pulse in IDLE must not produce a result or wake the block.
        meas_valid = 1'b1;
        meas_data  = 32'hDEAD;
        step();
        meas_valid = 1'b0;
        repeat (5) step();
        check("idle stray valid", res_valid, 1'b0);
        check("idle stray busy", busy, 1'b0);
        check("idle meas_rst_hi", meas_rst, 1'b1);
        check("idle res_data_kept", res_data, 32'h77);

        // Re-enable resumes at ch 2.
        enable = 1'b1;
        step();
        run_vec(vecs[13], 13);

        // Reset mid-MEASURE of ch 3.
        wait_measure(settle);
        check("rstm in_measure", meas_rst, 1'b0);
        lat = 0;
        repeat (3) begin
            step();
            lat++;
        end
        reset = 1'b1;
        step();
        check_reset_values("rst_mid");
        reset  = 1'b0;
        enable = 1'b0;
        step();
        check("post_rst busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
